// File: rtl/otter_hazard_unit.sv
// otter_hazard_unit -- hazard and forwarding controller for the pipelined OTTER RV32I core.
//
// A shift-register scoreboard follows the destination register of every
// instruction from EX onward. The unit raises a decode-stage stall on load-use
// hazards and a flush for a taken branch or jump resolved in EX. It also
// produces registered per-operand forwarding selects for the instruction
// entering EX.
//
// Optional feature: define OTTER_HAZARD_PERF_EN to build the saturating
// stall and flush cycle counters. When the macro is undefined, both counter
// ports are tied to 0.
//
// Ports:
//   CLK, RESET             clock; synchronous active-high reset
//   de_valid               decode holds a real instruction
//   de_rs1/_used           decode rs1 address and whether it is read
//   de_rs2/_used           decode rs2 address and whether it is read
//   de_rd, de_reg_write    decode destination and write enable
//   de_is_load             decode instruction is a LOAD
//   ex_br_taken            EX redirects the PC
//   stall                  hold PC and IF/DE, bubble into DE/EX
//   flush                  kill IF/DE and DE/EX
//   fwd_sel_a/_b           EX operand source: 0 = regfile, k = result k stages ahead
//   stall_count            stall cycles (perf build only)
//   flush_count            flush cycles (perf build only)
module otter_hazard_unit #(
   parameter int RA_W          = 5,
   parameter int FWD_STAGES    = 2,
   parameter int LOAD_LAT      = 1,
   parameter int FLUSH_BUBBLES = 2,
   parameter int CNT_W         = 32,
   localparam int FSW          = $clog2(FWD_STAGES+1)
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             de_valid,
   input  logic [RA_W-1:0]  de_rs1,
   input  logic             de_rs1_used,
   input  logic [RA_W-1:0]  de_rs2,
   input  logic             de_rs2_used,
   input  logic [RA_W-1:0]  de_rd,
   input  logic             de_reg_write,
   input  logic             de_is_load,
   input  logic             ex_br_taken,
   output logic             stall,
   output logic             flush,
   output logic [FSW-1:0]   fwd_sel_a,
   output logic [FSW-1:0]   fwd_sel_b,
   output logic [CNT_W-1:0] stall_count,
   output logic [CNT_W-1:0] flush_count
);

   // The counter is at least 2 bits wide and large enough to hold FLUSH_BUBBLES-1.
   localparam int FCW = (FLUSH_BUBBLES > 3) ? $clog2(FLUSH_BUBBLES) : 2;

   typedef struct packed {
      logic            vld;
      logic [RA_W-1:0] rd;
      logic            ld;
   } sb_ent_t;

   sb_ent_t          sb [1:FWD_STAGES];
   logic [FCW-1:0]   fl_cnt;
   logic [FSW-1:0]   win_a, win_b;
   logic             ld_a, ld_b;
   logic             hazard, adv, ins;

   // Find the winning producer for each operand. The scan runs from the oldest
   // entry to the youngest, so the smallest p is the last match written.
   always_comb begin
      win_a = '0;
      win_b = '0;
      ld_a  = 1'b0;
      ld_b  = 1'b0;
      for (int p = FWD_STAGES; p >= 1; p--) begin
         if (de_rs1_used && de_rs1 != '0 && sb[p].vld && sb[p].rd == de_rs1) begin
            win_a = FSW'(p);
            ld_a  = sb[p].ld;
         end
         if (de_rs2_used && de_rs2 != '0 && sb[p].vld && sb[p].rd == de_rs2) begin
            win_b = FSW'(p);
            ld_b  = sb[p].ld;
         end
      end
   end

   // Stall only if the youngest matching producer is a load that is still too
   // close to forward. An older load behind a younger ALU match does not stall.
   assign hazard = (ld_a && int'(win_a) <= LOAD_LAT) || (ld_b && int'(win_b) <= LOAD_LAT);
   assign flush  = ex_br_taken || (fl_cnt != '0);
   assign stall  = de_valid && hazard && !flush;
   assign adv    = !stall && !flush;
   assign ins    = de_valid && de_reg_write && (de_rd != '0) && adv;

   always_ff @(posedge CLK) begin
      if (RESET) begin
         for (int p = 1; p <= FWD_STAGES; p++) sb[p] <= '0;
         fl_cnt    <= '0;
         fwd_sel_a <= '0;
         fwd_sel_b <= '0;
      end else begin
         sb[1] <= ins ? '{vld: 1'b1, rd: de_rd, ld: de_is_load} : '0;
         for (int p = 2; p <= FWD_STAGES; p++) sb[p] <= sb[p-1];
         // A new redirect reloads the counter even while a flush is in progress.
         if (ex_br_taken)        fl_cnt <= FCW'(FLUSH_BUBBLES-1);
         else if (fl_cnt != '0)  fl_cnt <= fl_cnt - 1'b1;
         fwd_sel_a <= adv ? win_a : '0;
         fwd_sel_b <= adv ? win_b : '0;
      end
   end

`ifdef OTTER_HAZARD_PERF_EN
   logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

   always_ff @(posedge CLK) begin
      if (RESET) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         if (stall && stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + 1'b1;
         if (flush && flush_cnt_q != '1) flush_cnt_q <= flush_cnt_q + 1'b1;
      end
   end

   assign stall_count = stall_cnt_q;
   assign flush_count = flush_cnt_q;
`else
   assign stall_count = '0;
   assign flush_count = '0;
`endif

endmodule

// File: tb/tb_otter_hazard_unit.sv
// Directed testbench for otter_hazard_unit (RA_W=5, FWD_STAGES=2, LOAD_LAT=1,
// FLUSH_BUBBLES=2). Inputs change on the falling edge. Checks run 1 time unit
// later, so combinational outputs reflect the new inputs and registered
// outputs reflect the previous rising edge.
module tb_otter_hazard_unit;
   logic        CLK = 1'b0;
   logic        RESET;
   logic        de_valid, de_rs1_used, de_rs2_used, de_reg_write, de_is_load, ex_br_taken;
   logic [4:0]  de_rs1, de_rs2, de_rd;
   logic        stall, flush;
   logic [1:0]  fwd_sel_a, fwd_sel_b;
   logic [31:0] stall_count, flush_count;

   int n_cmp = 0;
   int n_bad = 0;

   otter_hazard_unit dut (
      .CLK(CLK), .RESET(RESET),
      .de_valid(de_valid), .de_rs1(de_rs1), .de_rs1_used(de_rs1_used),
      .de_rs2(de_rs2), .de_rs2_used(de_rs2_used), .de_rd(de_rd),
      .de_reg_write(de_reg_write), .de_is_load(de_is_load), .ex_br_taken(ex_br_taken),
      .stall(stall), .flush(flush), .fwd_sel_a(fwd_sel_a), .fwd_sel_b(fwd_sel_b),
      .stall_count(stall_count), .flush_count(flush_count)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // One decode cycle: v, rs1, rs1_used, rs2, rs2_used, rd, reg_write, is_load, br_taken.
   task automatic drv(input logic v, input logic [4:0] r1, input logic u1,
                      input logic [4:0] r2, input logic u2, input logic [4:0] rd,
                      input logic rw, input logic ld, input logic br);
      @(negedge CLK);
      de_valid = v;  de_rs1 = r1; de_rs1_used = u1; de_rs2 = r2; de_rs2_used = u2;
      de_rd = rd;    de_reg_write = rw; de_is_load = ld; ex_br_taken = br;
      #1;
   endtask

   task automatic idle();
      drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic do_rst();
      @(negedge CLK);
      RESET = 1'b1;
      de_valid = 0; de_rs1 = 0; de_rs1_used = 0; de_rs2 = 0; de_rs2_used = 0;
      de_rd = 0; de_reg_write = 0; de_is_load = 0; ex_br_taken = 0;
      @(negedge CLK);
      RESET = 1'b0;
      #1;
   endtask

   task automatic chk_cnt(input string tag, input logic [31:0] s_exp, input logic [31:0] f_exp);
`ifdef OTTER_HAZARD_PERF_EN
      chk({tag, "_stall_cnt"}, stall_count, s_exp);
      chk({tag, "_flush_cnt"}, flush_count, f_exp);
`else
      chk({tag, "_stall_cnt"}, stall_count, 32'd0);
      chk({tag, "_flush_cnt"}, flush_count, 32'd0);
`endif
   endtask

   // add x5,x1,x2 then add x6,x5,x3: no stall, forward A from EX/MEM.
   task automatic alu_pair(input string tag);
      drv(1, 1, 1, 2, 1, 5, 1, 0, 0);
      chk({tag, "_p1_stall"}, 32'(stall), 0);
      drv(1, 5, 1, 3, 1, 6, 1, 0, 0);
      chk({tag, "_p2_stall"}, 32'(stall), 0);
      idle();
      chk({tag, "_fwd_a"}, 32'(fwd_sel_a), 1);
      chk({tag, "_fwd_b"}, 32'(fwd_sel_b), 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      do_rst();
      chk("rst_stall", 32'(stall), 0);
      chk("rst_flush", 32'(flush), 0);
      chk("rst_fwd_a", 32'(fwd_sel_a), 0);
      chk("rst_fwd_b", 32'(fwd_sel_b), 0);
      chk_cnt("rst", 0, 0);

      alu_pair("alu");

      // lw x5 ; add x6,x3,x5 -> one stall cycle, then forward B from MEM/WB.
      drv(1, 1, 1, 0, 0, 5, 1, 1, 0);
      chk("lu_lw_stall", 32'(stall), 0);
      drv(1, 3, 1, 5, 1, 6, 1, 0, 0);
      chk("lu_stall1", 32'(stall), 1);
      drv(1, 3, 1, 5, 1, 6, 1, 0, 0);
      chk("lu_stall2", 32'(stall), 0);
      chk("lu_bubble_fwd_b", 32'(fwd_sel_b), 0);
      idle();
      chk("lu_fwd_b", 32'(fwd_sel_b), 2);
      chk("lu_fwd_a", 32'(fwd_sel_a), 0);

      // addi x7 twice, then use x7 in both operands -> youngest (1) wins.
      drv(1, 1, 1, 0, 0, 7, 1, 0, 0);
      drv(1, 1, 1, 0, 0, 7, 1, 0, 0);
      drv(1, 7, 1, 7, 1, 8, 1, 0, 0);
      chk("mp_stall", 32'(stall), 0);
      idle();
      chk("mp_fwd_a", 32'(fwd_sel_a), 1);
      chk("mp_fwd_b", 32'(fwd_sel_b), 1);

      // rd=x0 is never tracked; an unused rs2 never matches, even a load producer.
      drv(1, 1, 1, 2, 1, 0, 1, 0, 0);
      drv(1, 1, 1, 0, 0, 9, 1, 1, 0);
      drv(1, 0, 1, 9, 0, 10, 1, 0, 0);
      chk("x0_stall", 32'(stall), 0);
      idle();
      chk("x0_fwd_a", 32'(fwd_sel_a), 0);
      chk("x0_fwd_b", 32'(fwd_sel_b), 0);

      // An invalid decode slot never stalls, even when its fields look like a load-use.
      drv(1, 1, 1, 0, 0, 13, 1, 1, 0);
      drv(0, 13, 1, 13, 1, 14, 1, 0, 0);
      chk("inv_stall", 32'(stall), 0);
      idle();

      // A taken branch coinciding with a load-use: flush wins for 2 cycles.
      do_rst();
      drv(1, 1, 1, 0, 0, 11, 1, 1, 0);
      drv(1, 3, 1, 11, 1, 12, 1, 0, 1);
      chk("fl_flush1", 32'(flush), 1);
      chk("fl_stall1", 32'(stall), 0);
      drv(1, 3, 1, 11, 1, 12, 1, 0, 0);
      chk("fl_flush2", 32'(flush), 1);
      chk("fl_stall2", 32'(stall), 0);
      chk("fl_fwd_b", 32'(fwd_sel_b), 0);
      drv(1, 12, 1, 11, 1, 15, 1, 0, 0);
      chk("fl_flush3", 32'(flush), 0);
      chk("fl_stall3", 32'(stall), 0);
      chk_cnt("fl", 0, 2);
      idle();
      chk("fl_bubble_fwd_a", 32'(fwd_sel_a), 0);
      chk("fl_bubble_fwd_b", 32'(fwd_sel_b), 0);

      // A second redirect during the flush reloads the counter.
      drv(0, 0, 0, 0, 0, 0, 0, 0, 1);
      drv(0, 0, 0, 0, 0, 0, 0, 0, 1);
      idle();
      chk("rl_flush", 32'(flush), 1);
      idle();
      chk("rl_flush_end", 32'(flush), 0);

      // RESET during a stall cycle.
      do_rst();
      drv(1, 1, 1, 0, 0, 5, 1, 1, 0);
      drv(1, 3, 1, 5, 1, 6, 1, 0, 0);
      chk("rs_stall_pre", 32'(stall), 1);
      RESET = 1'b1;
      drv(1, 3, 1, 5, 1, 6, 1, 0, 0);
      RESET = 1'b0;
      #1;
      chk("rs_stall", 32'(stall), 0);
      chk("rs_flush", 32'(flush), 0);
      chk("rs_fwd_b0", 32'(fwd_sel_b), 0);
      chk_cnt("rs", 0, 0);
      idle();
      chk("rs_fwd_b", 32'(fwd_sel_b), 0);

      // RESET during a flush cycle.
      drv(0, 0, 0, 0, 0, 0, 0, 0, 1);
      chk("rf_flush_pre", 32'(flush), 1);
      RESET = 1'b1;
      idle();
      RESET = 1'b0;
      #1;
      chk("rf_flush", 32'(flush), 0);
      chk("rf_stall", 32'(stall), 0);
      chk("rf_fwd_a", 32'(fwd_sel_a), 0);
      chk_cnt("rf", 0, 0);

      alu_pair("post_rst");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/otter_hazard_unit.md
Name: otter_hazard_unit

Overview:
- Parametrised hazard and forwarding controller for the pipelined OTTER RV32I core.
- Replaces the hard-wired pcWrite=1 / no-hazard assumption of the first pipeline.
- Keeps a shift-register scoreboard of in-flight destination registers (EX onward).
- Produces the decode-stage stall, the branch flush, and registered per-operand forwarding selects for the instruction entering EX.

Parameters:
- RA_W, 5, register address width.
- FWD_STAGES, 2, number of post-decode stages that can forward (1=EX/MEM, 2=MEM/WB, ...); scoreboard depth.
- LOAD_LAT, 1, a load result is forwardable only from stage positions > LOAD_LAT.
- FLUSH_BUBBLES, 2, cycles of flush after a taken branch/jump resolved in EX.
- CNT_W, 32, performance counter width.

Ports:
- CLK  in  1  clock.
- RESET  in  1  synchronous active-high reset.
- de_valid  in  1  decode holds a real instruction.
- de_rs1  in  RA_W  decode rs1 address.
- de_rs1_used  in  1  rs1 read by instruction.
- de_rs2  in  RA_W  decode rs2 address.
- de_rs2_used  in  1  rs2 read by instruction.
- de_rd  in  RA_W  decode destination.
- de_reg_write  in  1  instruction writes rd.
- de_is_load  in  1  instruction is LOAD.
- ex_br_taken  in  1  EX redirects PC (taken branch, JAL, JALR).
- stall  out  1  hold PC and IF/DE, insert bubble into DE/EX.
- flush  out  1  kill IF/DE and DE/EX contents.
- fwd_sel_a  out  FSW=$clog2(FWD_STAGES+1)  EX operand A source; 0=register file, k=result k stages ahead of EX.
- fwd_sel_b  out  FSW  as fwd_sel_a for operand B.
- stall_count  out  CNT_W  stall cycles (optional feature).
- flush_count  out  CNT_W  flush cycles (optional feature).

Behaviour:
- Clock and reset: one clock CLK; RESET is synchronous, active-high.
- Reset: scoreboard entries invalid, flush counter 0, fwd_sel_a/b=0, stall=0, flush=0, counters 0.
- Scoreboard entries: entry p (p=1..FWD_STAGES) = {valid, rd, is_load} of the instruction p stages past decode (p=1 in EX).
- Shift: every cycle entries shift p->p+1; the last entry is discarded.
- Entry 1 loads from decode when de_valid & de_reg_write & de_rd!=0 & !stall & !flush. Otherwise it loads a bubble (valid=0).
- Match: operand X matches entry p when X_used, entry valid, and rd==X. x0 never matches.
- If several entries match, the smallest p (youngest producer) wins.
- Load-use: a matching load entry at position p<=LOAD_LAT makes stall=1 (combinational, same cycle).
- After a stall the producer advances and p increments. LOAD_LAT=1 gives exactly one stall cycle for an adjacent lw/use.
- fwd_sel: registered each cycle to the winning p for the decode instruction when it advances (!stall & !flush); else 0.
- Non-matching operands get 0. Producers older than FWD_STAGES are assumed already written to the register file.
- Flush: flush=1 combinationally in the ex_br_taken cycle.
- The 2-bit+ down-counter is loaded with FLUSH_BUBBLES-1; flush stays high while the counter is non-zero.
- A new ex_br_taken while the counter is non-zero reloads the counter.
- Flush and stall together: flush wins, stall is forced 0 that cycle.
- de_valid=0: no stall, no entry insert.
- RESET mid-stall or mid-flush: outputs return to reset values on the next edge.
- FLUSH_BUBBLES=1: flush only in the ex_br_taken cycle.

Optional Feature:
- Macro: OTTER_HAZARD_PERF_EN.
- Defined: stall_count increments on every cycle with stall=1; flush_count increments on every cycle with flush=1. Both saturate at all-ones and clear on RESET.
- Undefined: no counter registers; both ports tied to 0, so the port list is unchanged.

Test Plan:
- Back-to-back ALU dependency: add x5,x1,x2 then add x6,x5,x3 -> no stall; fwd_sel_a=1 when the second add is in EX.
- Load-use with LOAD_LAT=1: lw x5 then add x6,x3,x5 -> stall=1 for exactly one cycle, bubble inserted; fwd_sel_b=2 when add is in EX.
- Multiple producers: addi x7 twice in a row, then use x7 in rs1 and rs2 -> fwd_sel_a=fwd_sel_b=1 (youngest), not 2.
- x0 and unused operands: producer rd=x0, or consumer with rs2_used=0 matching rd -> fwd_sel=0, no stall.
- Branch flush with FLUSH_BUBBLES=2, ex_br_taken coinciding with a load-use condition -> flush=1 for 2 cycles, stall=0, entry 1 bubbles both cycles; with perf enabled, flush_count=2, stall_count=0.
- RESET asserted during a stall cycle and during a flush cycle -> next edge: stall=0, flush=0, fwd_sel=0, counters 0; a following dependent pair behaves as in the first scenario.
